// File: rtl/cook_power_ctrl.sv
// rtl/cook_power_ctrl.sv - microwave cook-cycle FSM with slot-based duty-cycled magnetron
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   tick              one-cycle 100 ms strobe; SLOTS ticks make one second
//   start, stop       one-cycle start/resume and pause/cancel pulses
//   door_open         door sensor level, 1 = open
//   mode[1:0]         00 LOW, 01 MED, 10 HIGH, 11 DEFROST
//   cook_time[TW-1:0] requested cook time in seconds
//   magnetron         magnetron enable (gated by the door without latency)
//   idle/running/paused  state decodes
//   done              one-cycle completion pulse
//   remaining[TW-1:0] seconds left
module cook_power_ctrl #(
    parameter int SLOTS = 10,
    parameter int TW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic          stop,
    input  logic          door_open,
    input  logic [1:0]    mode,
    input  logic [TW-1:0] cook_time,
    output logic          magnetron,
    output logic          idle,
    output logic          running,
    output logic          paused,
    output logic          done,
    output logic [TW-1:0] remaining
);

    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_slot, w_slot_nxt;
    logic [TW-1:0] r_remaining, w_remaining_nxt;
    logic [1:0]    r_mode_q, w_mode_nxt;
    logic          r_mag_q, w_mag_nxt;
    logic          w_wrap;

    // On-slots per window; HIGH keeps the magnetron on for the whole window.
    function automatic logic [7:0] duty(input logic [1:0] m);
        case (m)
            2'b00:   duty = 8'd3;
            2'b01:   duty = 8'd6;
            2'b10:   duty = 8'(SLOTS);
            default: duty = 8'd2;
        endcase
    endfunction

    assign w_wrap = (r_slot == SW'(SLOTS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_slot      <= '0;
            r_remaining <= '0;
            r_mode_q    <= 2'b00;
            r_mag_q     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_slot      <= w_slot_nxt;
            r_remaining <= w_remaining_nxt;
            r_mode_q    <= w_mode_nxt;
            r_mag_q     <= w_mag_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_slot_nxt      = r_slot;
        w_remaining_nxt = r_remaining;
        w_mode_nxt      = r_mode_q;
        case (r_state)
            S_IDLE: begin
                // stop in the same cycle cancels the start
                if (start && !stop && !door_open && cook_time != '0) begin
                    w_state_nxt     = S_RUN;
                    w_remaining_nxt = cook_time;
                    w_mode_nxt      = mode;
                    w_slot_nxt      = '0;
                end
            end
            S_RUN: begin
                // pause has priority over a coincident tick, so the tick is lost
                if (stop || door_open) begin
                    w_state_nxt = S_PAUSE;
                end else if (tick) begin
                    if (w_wrap) begin
                        w_slot_nxt = '0;
                        if (r_remaining != '0) begin
                            w_remaining_nxt = r_remaining - TW'(1);
                            if (r_remaining == TW'(1)) begin
                                w_state_nxt = S_DONE;
                            end
                        end
                    end else begin
                        w_slot_nxt = r_slot + SW'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    w_state_nxt     = S_IDLE;
                    w_remaining_nxt = '0;
                end else if (start && !door_open) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Registered enable looks at the upcoming slot so it lines up with the state.
        w_mag_nxt = (w_state_nxt == S_RUN) && (8'(w_slot_nxt) < duty(w_mode_nxt));
    end

    always_comb begin
        idle      = (r_state == S_IDLE);
        running   = (r_state == S_RUN);
        paused    = (r_state == S_PAUSE);
        done      = (r_state == S_DONE);
        remaining = r_remaining;
        magnetron = r_mag_q & ~door_open;
    end

endmodule

// File: tb/tb_cook_power_ctrl.sv
// tb/tb_cook_power_ctrl.sv - self-checking bench for cook_power_ctrl
module tb_cook_power_ctrl;

    localparam int SLOTS = 10;
    localparam int TW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          door_open = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [TW-1:0] cook_time = '0;
    logic          magnetron, idle, running, paused, done;
    logic [TW-1:0] remaining;

    cook_power_ctrl #(.SLOTS(SLOTS), .TW(TW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .door_open(door_open), .mode(mode), .cook_time(cook_time),
        .magnetron(magnetron), .idle(idle), .running(running), .paused(paused),
        .done(done), .remaining(remaining)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: job progress as total ticks elapsed; slot and
    // remaining seconds follow from integer division.
    int m_phase = 0;   // 0 idle, 1 run, 2 pause, 3 done
    int m_el    = 0;
    int m_cook  = 0;
    int m_modeq = 0;

    function automatic int m_duty(input int mq);
        case (mq)
            0:       return 3;
            1:       return 6;
            2:       return 10;
            default: return 2;
        endcase
    endfunction

    task automatic model_update();
        if (rst) begin
            m_phase = 0; m_el = 0; m_cook = 0; m_modeq = 0;
        end else begin
            case (m_phase)
                0: if (start && !stop && !door_open && cook_time != 0) begin
                       m_phase = 1; m_cook = int'(cook_time); m_el = 0; m_modeq = int'(mode);
                   end
                1: if (stop || door_open) m_phase = 2;
                   else if (tick) begin
                       m_el++;
                       if (m_el == m_cook * SLOTS) m_phase = 3;
                   end
                2: if (stop) begin
                       m_phase = 0; m_cook = 0; m_el = 0;
                   end else if (start && !door_open) m_phase = 1;
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({magnetron, idle, running, paused, done, remaining});
    endfunction

    function automatic logic [31:0] model_vec();
        logic m_mag;
        m_mag = (m_phase == 1) && ((m_el % SLOTS) < m_duty(m_modeq)) && !door_open;
        return 32'({m_mag, m_phase == 0, m_phase == 1, m_phase == 2, m_phase == 3,
                    TW'(m_cook - m_el / SLOTS)});
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic pulses_off();
        rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic do_reset();
        pulses_off(); door_open = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic tick_step(input string name);
        tick = 1'b1; step(); tick = 1'b0;
        check(name, dut_vec(), model_vec());
    endtask

    typedef struct {
        logic          r, t, s, p, d;
        logic [1:0]    m;
        logic [TW-1:0] ct;
        logic          e_mag, e_idle, e_run, e_pause, e_done;
        logic [TW-1:0] e_rem;
    } vec_t;

    function automatic vec_t mk(input logic r, t, s, p, d, input logic [1:0] m, input int ct,
                                input logic em, ei, er, ep, ed, input int erem);
        vec_t v;
        v.r = r; v.t = t; v.s = s; v.p = p; v.d = d; v.m = m; v.ct = TW'(ct);
        v.e_mag = em; v.e_idle = ei; v.e_run = er; v.e_pause = ep; v.e_done = ed;
        v.e_rem = TW'(erem);
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        int on_cnt, d_cnt, total;
        logic [9:0] pat;

        //              r t s p d  m  ct   mag idl run pau dn rem
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 2, 0,  0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 1, 2, 5,  0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 0, 2, 5,  0, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 0, 0, 5,  1, 0, 1, 0, 0, 5);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0, 5,  1, 0, 1, 0, 0, 5);
        tbl[6]  = mk(0, 1, 0, 0, 0, 0, 5,  1, 0, 1, 0, 0, 5);
        tbl[7]  = mk(0, 1, 0, 0, 0, 0, 5,  0, 0, 1, 0, 0, 5);
        tbl[8]  = mk(0, 1, 0, 1, 0, 0, 5,  0, 0, 0, 1, 0, 5);
        tbl[9]  = mk(0, 0, 0, 0, 0, 2, 5,  0, 0, 0, 1, 0, 5);
        tbl[10] = mk(0, 0, 1, 0, 0, 2, 5,  0, 0, 1, 0, 0, 5);
        tbl[11] = mk(0, 1, 0, 0, 0, 2, 5,  0, 0, 1, 0, 0, 5);
        tbl[12] = mk(0, 0, 0, 1, 0, 2, 5,  0, 0, 0, 1, 0, 5);
        tbl[13] = mk(0, 0, 0, 1, 0, 2, 5,  0, 1, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 1, 0, 0, 2, 3,  1, 0, 1, 0, 0, 3);
        tbl[15] = mk(0, 1, 0, 0, 0, 2, 3,  1, 0, 1, 0, 0, 3);
        tbl[16] = mk(0, 0, 0, 0, 0, 2, 3,  1, 0, 1, 0, 0, 3);

        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].r; tick = tbl[i].t; start = tbl[i].s; stop = tbl[i].p;
            door_open = tbl[i].d; mode = tbl[i].m; cook_time = tbl[i].ct;
            step();
            check($sformatf("tbl[%0d]", i), dut_vec(),
                  32'({tbl[i].e_mag, tbl[i].e_idle, tbl[i].e_run, tbl[i].e_pause,
                       tbl[i].e_done, tbl[i].e_rem}));
        end
        pulses_off(); door_open = 1'b0;

        // Reset in the middle of a run returns everything to reset values.
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_mid_run", dut_vec(), 32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, TW'(0)}));

        // HIGH for 2 s: magnetron on in every one of the 20 slots.
        do_reset();
        mode = 2'b10; cook_time = TW'(2); start = 1'b1; step(); start = 1'b0;
        check("high_start", dut_vec(), model_vec());
        on_cnt = 0; d_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            on_cnt += int'(magnetron);
            tick_step($sformatf("high_tick%0d", k));
            d_cnt += int'(done);
            if (k == 9) check("high_rem_after_1s", 32'(remaining), 32'd1);
        end
        step(); d_cnt += int'(done);
        step(); d_cnt += int'(done);
        check("high_on_slots", 32'(on_cnt), 32'd20);
        check("high_done_pulses", 32'(d_cnt), 32'd1);
        check("high_final", dut_vec(), 32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, TW'(0)}));

        // LOW for 1 s: on in slots 0-2 only.
        do_reset();
        mode = 2'b00; cook_time = TW'(1); start = 1'b1; step(); start = 1'b0;
        pat = '0;
        for (int k = 0; k < 10; k++) begin
            pat[k] = magnetron;
            tick_step($sformatf("low_tick%0d", k));
        end
        check("low_pattern", 32'(pat), 32'h007);
        check("low_done", 32'(done), 32'd1);
        step();
        check("low_idle_after_done", 32'({idle, done}), 32'b10);

        // MED for 3 s with a door opening after slot 4 begins.
        do_reset();
        mode = 2'b01; cook_time = TW'(3); start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 4; k++) tick_step($sformatf("med_tick%0d", k));
        check("med_mag_before_door", 32'(magnetron), 32'd1);
        door_open = 1'b1; #1;
        check("med_door_gate_comb", 32'(magnetron), 32'd0);
        step();
        check("med_paused", 32'({paused, remaining}), 32'({1'b1, TW'(3)}));
        door_open = 1'b0; mode = 2'b10; start = 1'b1; step(); start = 1'b0;
        check("med_resume", dut_vec(), model_vec());
        total = 4;
        for (int k = 0; k < 100 && !done; k++) begin
            tick_step("med_run");
            total++;
        end
        check("med_total_ticks", 32'(total), 32'd30);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            rst   = ($urandom_range(299) == 0);
            tick  = ($urandom_range(1) == 0);
            start = ($urandom_range(7) == 0);
            stop  = ($urandom_range(39) == 0);
            if ($urandom_range(29) == 0) door_open = ~door_open;
            mode      = 2'($urandom_range(3));
            cook_time = TW'($urandom_range(3));
            step();
            check("random", dut_vec(), model_vec());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
